// File: rtl/fp_mul_norm_round_ctrl.sv
// fp_mul_norm_round_ctrl: turns a raw 48-bit significand product, biased
// exponent sum and sign into a packed IEEE-754 single. Normalizes by one bit,
// denormalizes one bit per cycle with sticky collection, rounds to nearest
// even and saturates overflow to infinity. Valid/ready on both sides.
module fp_mul_norm_round_ctrl #(
  parameter int MAX_DSHIFT = 26
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [47:0]        prod,
  input  logic signed [9:0]  exp_sum,
  input  logic               sign,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        result,
  output logic               overflow,
  output logic               underflow
);

  localparam logic [4:0] MAX_CNT = 5'(MAX_DSHIFT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NORM,
    S_DENORM,
    S_ROUND,
    S_OUT
  } state_t;

  state_t             state_q, state_d;
  logic [47:0]        prod_q, prod_d;
  logic signed [9:0]  exps_q, exps_d;
  logic               sign_q, sign_d;
  logic [24:0]        mant_q, mant_d;
  logic               sticky_q, sticky_d;
  logic signed [10:0] exp_q, exp_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [31:0]        result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  logic signed [11:0] exp_norm;
  logic [24:0]        round_sum;
  logic signed [10:0] exp_rnd;

  // Subnormal shift count 1-exp, clipped so huge shifts become pure sticky.
  function automatic logic [4:0] sat_shift(input logic signed [11:0] e);
    logic signed [11:0] d;
    d = 12'sd1 - e;
    if (d > MAX_DSHIFT) return MAX_CNT;
    return d[4:0];
  endfunction

  // Round-to-nearest-even: drop the guard bit, increment on g & (sticky | lsb).
  function automatic logic [24:0] rne_sum(input logic [24:0] m, input logic st);
    logic inc;
    inc = m[0] & (st | m[1]);
    return {1'b0, m[24:1]} + {24'd0, inc};
  endfunction

  // Sequencer next state and working-register updates.
  always_comb begin
    state_d   = state_q;
    prod_d    = prod_q;
    exps_d    = exps_q;
    sign_d    = sign_q;
    mant_d    = mant_q;
    sticky_d  = sticky_q;
    exp_d     = exp_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    exp_norm  = $signed({{2{exps_q[9]}}, exps_q}) + (prod_q[47] ? 12'sd1 : 12'sd0);
    round_sum = rne_sum(mant_q, sticky_q);
    exp_rnd   = exp_q;
    if (round_sum[24]) begin
      exp_rnd = exp_q + 11'sd1;
    end else if (exp_q == 11'sd0 && round_sum[23]) begin
      exp_rnd = 11'sd1;
    end
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          prod_d  = prod;
          exps_d  = exp_sum;
          sign_d  = sign;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (prod_q == 48'd0) begin
          result_d = {sign_q, 31'd0};
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          state_d  = S_OUT;
        end else begin
          if (prod_q[47]) begin
            mant_d   = prod_q[47:23];
            sticky_d = |prod_q[22:0];
          end else begin
            mant_d   = prod_q[46:22];
            sticky_d = |prod_q[21:0];
          end
          if (exp_norm <= 12'sd0) begin
            cnt_d   = sat_shift(exp_norm);
            exp_d   = 11'sd0;
            state_d = S_DENORM;
          end else begin
            exp_d   = exp_norm[10:0];
            state_d = S_ROUND;
          end
        end
      end
      S_DENORM: begin
        sticky_d = sticky_q | mant_q[0];
        mant_d   = mant_q >> 1;
        cnt_d    = cnt_q - 5'd1;
        if (cnt_q <= 5'd1) state_d = S_ROUND;
      end
      S_ROUND: begin
        if (exp_rnd >= 11'sd255) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          ovf_d    = 1'b1;
          unf_d    = 1'b0;
        end else begin
          result_d = {sign_q, exp_rnd[7:0], round_sum[24] ? 23'd0 : round_sum[22:0]};
          ovf_d    = 1'b0;
          unf_d    = (exp_rnd == 11'sd0) & (mant_q[0] | sticky_q);
        end
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and visible outputs; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Operand and working datapath registers; only meaningful while busy.
  always_ff @(posedge clk) begin
    prod_q   <= prod_d;
    exps_q   <= exps_d;
    sign_q   <= sign_d;
    mant_q   <= mant_d;
    sticky_q <= sticky_d;
    exp_q    <= exp_d;
    cnt_q    <= cnt_d;
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule
